decoder_scan: RTL and testbench

- Parametrised, registered successor to the combinational 3-to-8 decoder.
- Decodes a SEL_W-bit index into a one-hot 2**SEL_W-bit output in one of two modes:
  - direct: decode on a load strobe;
  - scan: walk the one-hot bit through every output, holding each for a programmable dwell.
- Drives row/column select, chip-select and LED-scan style fabric from one clocked block.

---
 rtl/decoder_pkg.sv | 33 +++
 rtl/decoder_scan_dwell_timer.sv | 45 ++++
 rtl/decoder_scan.sv | 141 ++++++++++++++
 tb/tb_decoder_scan.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared types, default widths and the one-hot helper for the
//               registered decoder / scanner.
//               Optional feature macro: DECODER_SCAN_WRAP_EN (used by the top)
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

   localparam int c_sel_w_default   = 3;
   localparam int c_dwell_w_default = 4;

   // Widest index the helper supports; callers narrow the result themselves.
   localparam int c_sel_w_max = 8;
   localparam int c_out_w_max = 1 << c_sel_w_max;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   // One-hot code for idx at the widest supported width.
   function automatic logic [c_out_w_max-1:0] onehot(input logic [c_sel_w_max-1:0] idx);
      logic [c_out_w_max-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_scan_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Per-index dwell counter for the scanner. Loads D = max(dwell,1)
//               on a start, counts enabled cycles 1..D and flags the D-th one.
//               Holds its count while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer
   import decoder_pkg::*;
#(
   parameter int DWELL_W = c_dwell_w_default
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               load,
   input  logic               run,
   input  logic [DWELL_W-1:0] dwell,
   output logic               tick
);

   logic [DWELL_W-1:0] r_d;
   logic [DWELL_W-1:0] r_cnt;

   // r_cnt is the position (1..D) of the current cycle within the dwell.
   assign tick = run & en & (r_cnt == r_d);

   // Capture the dwell on start, then count enabled cycles while scanning.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d   <= '0;
         r_cnt <= '0;
      end else if (load) begin
         r_d   <= (dwell == '0) ? DWELL_W'(1) : dwell;
         r_cnt <= DWELL_W'(1);
      end else if (!run) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= tick ? DWELL_W'(1) : r_cnt + DWELL_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan
// Description : Registered SEL_W-to-2**SEL_W one-hot decoder with a direct
//               (load-strobed) mode and a scan mode that walks the hot bit
//               across every output with a programmable dwell.
//               Optional feature macro: DECODER_SCAN_WRAP_EN - when defined,
//               a scan with mode=1 at the end of the last dwell wraps to
//               index 0 instead of stopping.
//               SEL_W must not exceed decoder_pkg::c_sel_w_max.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan
   import decoder_pkg::*;
#(
   parameter  int SEL_W   = c_sel_w_default,
   parameter  int DWELL_W = c_dwell_w_default,
   localparam int OUT_W   = 1 << SEL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   a,
   input  logic               load,
   input  logic               start,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   y,
   output logic               valid,
   output logic               busy,
   output logic               done
);

   localparam logic [SEL_W-1:0] c_last_idx = '1;

   state_t                 r_state;
   logic [SEL_W-1:0]       r_idx;
   logic [OUT_W-1:0]       r_y;
   logic                   r_valid;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_scan_start;
   logic                   w_direct_load;
   logic                   w_run;
   logic                   w_tick;
   logic                   w_wrap;
   logic [c_sel_w_max-1:0] w_a_ext;

   // Strobes are only honoured outside a scan; mode picks load vs start.
   assign w_scan_start  = en &  mode & start & (r_state != SCAN);
   assign w_direct_load = en & ~mode & load  & (r_state != SCAN);
   assign w_run         = (r_state == SCAN);
   assign w_a_ext       = c_sel_w_max'(a);

`ifdef DECODER_SCAN_WRAP_EN
   assign w_wrap = mode;
`else
   assign w_wrap = 1'b0;
`endif

   dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .load  (w_scan_start),
      .run   (w_run),
      .dwell (dwell),
      .tick  (w_tick)
   );

   // Mode FSM together with the index, output and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_y     <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DIRECT: begin
               if (w_scan_start) begin
                  r_state <= SCAN;
                  r_idx   <= '0;
                  r_y     <= OUT_W'(1);
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
               end else if (w_direct_load) begin
                  r_state <= DIRECT;
                  r_idx   <= a;
                  r_y     <= OUT_W'(onehot(w_a_ext));
                  r_valid <= 1'b1;
               end else if (!en && r_state == DIRECT) begin
                  // Dropping en clears a direct decode.
                  r_state <= IDLE;
                  r_y     <= '0;
                  r_valid <= 1'b0;
               end
            end
            SCAN: begin
               if (w_tick) begin
                  if (r_idx != c_last_idx) begin
                     r_idx <= r_idx + SEL_W'(1);
                     r_y   <= r_y << 1;
                  end else if (w_wrap) begin
                     // Seamless wrap: each completed pass still reports done.
                     r_idx  <= '0;
                     r_y    <= OUT_W'(1);
                     r_done <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_idx   <= '0;
                     r_y     <= '0;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_y     <= '0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign y     = r_y;
   assign valid = r_valid;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan
// Description : Self-checking bench for decoder_scan. Expected outputs come
//               from a timeline model: after a start, the k-th enabled cycle
//               shows index k/D; the pass ends after OUT_W*D enabled cycles.
//               Optional feature macro: DECODER_SCAN_WRAP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan;

   localparam int SEL_W   = 3;
   localparam int DWELL_W = 4;
   localparam int OUT_W   = 1 << SEL_W;

   logic               clk   = 1'b0;
   logic               rst_n = 1'b0;
   logic               en    = 1'b0;
   logic               mode  = 1'b0;
   logic [SEL_W-1:0]   a     = '0;
   logic               load  = 1'b0;
   logic               start = 1'b0;
   logic [DWELL_W-1:0] dwell = '0;
   logic [OUT_W-1:0]   y;
   logic               valid;
   logic               busy;
   logic               done;

   int n_checks = 0;
   int n_fail   = 0;

   decoder_scan #(
      .SEL_W   (SEL_W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .a     (a),
      .load  (load),
      .start (start),
      .dwell (dwell),
      .y     (y),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      n_checks++;
      if ({y, valid, busy, done} !== {OUT_W'(0), 3'b000}) begin
         n_fail++;
         $display("FAIL reset: y=%h v=%b b=%b d=%b, expected all zero", y, valid, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({y, valid, busy, done} !== {OUT_W'(0), 3'b000}) begin
         n_fail++;
         $display("FAIL reset_release: y=%h v=%b b=%b d=%b, expected all zero", y, valid, busy, done);
      end
   endtask

   task automatic test_direct();
      logic [SEL_W-1:0] av;
      logic [OUT_W-1:0] ey;
      en   = 1'b1;
      mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         av   = (i == 0) ? SEL_W'(5) : (i == 1) ? SEL_W'(0) : SEL_W'($urandom);
         ey   = OUT_W'(1) << av;
         a    = av;
         load = 1'b1;
         step();
         load = 1'b0;
         a    = SEL_W'($urandom);
         n_checks++;
         if ({y, valid, busy, done} !== {ey, 3'b100}) begin
            n_fail++;
            $display("FAIL direct_load a=%0d: y=%h v=%b b=%b d=%b, expected y=%h v=1 b=0 d=0",
                     av, y, valid, busy, done, ey);
         end
         step();
         n_checks++;
         if ({y, valid, busy, done} !== {ey, 3'b100}) begin
            n_fail++;
            $display("FAIL direct_hold a=%0d: y=%h v=%b b=%b d=%b, expected y=%h v=1 b=0 d=0",
                     av, y, valid, busy, done, ey);
         end
      end
      en = 1'b0;
      step();
      n_checks++;
      if ({y, valid, busy, done} !== {OUT_W'(0), 3'b000}) begin
         n_fail++;
         $display("FAIL direct_en_off: y=%h v=%b b=%b d=%b, expected all zero", y, valid, busy, done);
      end
      a    = SEL_W'(2);
      load = 1'b1;
      step();
      load = 1'b0;
      n_checks++;
      if ({y, valid, busy, done} !== {OUT_W'(0), 3'b000}) begin
         n_fail++;
         $display("FAIL direct_load_while_disabled: y=%h v=%b b=%b d=%b, expected all zero",
                  y, valid, busy, done);
      end
      en = 1'b1;
   endtask

   task automatic test_simultaneous();
      en    = 1'b1;
      mode  = 1'b0;
      a     = SEL_W'(3);
      load  = 1'b1;
      start = 1'b1;
      step();
      load  = 1'b0;
      start = 1'b0;
      n_checks++;
      if ({y, valid, busy, done} !== {OUT_W'(8), 3'b100}) begin
         n_fail++;
         $display("FAIL load_and_start_mode0: y=%h v=%b b=%b d=%b, expected y=08 v=1 b=0 d=0",
                  y, valid, busy, done);
      end
   endtask

   // Start a scan (load and start both asserted, mode=1) and follow it to done.
   task automatic scan_check(input string name, input int dw, input int drop_pct,
                             input bit noise, input int freeze_k, input int freeze_len);
      int               d;
      int               total;
      int               k;
      int               off;
      int               frz;
      int               cycles;
      bit               en_now;
      logic [OUT_W-1:0] ey;
      logic             ev;
      logic             eb;
      logic             ed;
      d      = (dw == 0) ? 1 : dw;
      total  = OUT_W * d;
      en     = 1'b1;
      mode   = 1'b1;
      start  = 1'b1;
      load   = 1'b1;
      a      = SEL_W'($urandom);
      dwell  = DWELL_W'(dw);
      step();
      start  = 1'b0;
      load   = 1'b0;
`ifdef DECODER_SCAN_WRAP_EN
      mode   = 1'b0;
`endif
      k      = 0;
      off    = 0;
      frz    = 0;
      cycles = 0;
      forever begin
         if (k < total) begin
            ey = OUT_W'(1) << (k / d);
            {ev, eb, ed} = 3'b110;
         end else begin
            ey = '0;
            {ev, eb, ed} = 3'b001;
         end
         n_checks++;
         if ({y, valid, busy, done} !== {ey, ev, eb, ed}) begin
            n_fail++;
            $display("FAIL %s k=%0d: y=%h v=%b b=%b d=%b, expected y=%h v=%b b=%b d=%b",
                     name, k, y, valid, busy, done, ey, ev, eb, ed);
         end
         if (k >= total) break;
         en_now = 1'b1;
         if (freeze_k >= 0 && k == freeze_k && frz < freeze_len) begin
            en_now = 1'b0;
            frz++;
         end else if (drop_pct > 0 && $urandom_range(99) < drop_pct) begin
            en_now = 1'b0;
         end
         en = en_now;
         if (noise || !en_now) begin
            start = 1'($urandom);
            load  = 1'($urandom);
            a     = SEL_W'($urandom);
            dwell = DWELL_W'($urandom);
            mode  = 1'($urandom);
`ifdef DECODER_SCAN_WRAP_EN
            mode  = 1'b0;
`endif
         end
         step();
         cycles++;
         if (en_now) k++;
         else        off++;
         if (cycles > 4000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: k=%0d after %0d cycles, required %0d", name, k, cycles, total);
            break;
         end
      end
      en    = 1'b1;
      start = 1'b0;
      load  = 1'b0;
      mode  = 1'b1;
      step();
      n_checks++;
      if ({y, valid, busy, done} !== {OUT_W'(0), 3'b000}) begin
         n_fail++;
         $display("FAIL %s after_done: y=%h v=%b b=%b d=%b, expected all zero",
                  name, y, valid, busy, done);
      end
      if (drop_pct == 0) begin
         n_checks++;
         if (cycles !== total + freeze_len) begin
            n_fail++;
            $display("FAIL %s duration: %0d cycles start-to-done, expected %0d",
                     name, cycles, total + freeze_len);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      en    = 1'b1;
      mode  = 1'b1;
      dwell = DWELL_W'(1);
      start = 1'b1;
      step();
      start = 1'b0;
`ifdef DECODER_SCAN_WRAP_EN
      mode  = 1'b0;
`endif
      for (int i = 0; i < 4; i++) step();
      n_checks++;
      if ({y, busy} !== {OUT_W'(8'h10), 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_scan_pre: y=%h b=%b, expected y=10 b=1", y, busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({y, valid, busy, done} !== {OUT_W'(0), 3'b000}) begin
         n_fail++;
         $display("FAIL reset_async: y=%h v=%b b=%b d=%b, expected all zero", y, valid, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({y, valid, busy, done} !== {OUT_W'(0), 3'b000}) begin
            n_fail++;
            $display("FAIL reset_hold %0d: y=%h v=%b b=%b d=%b, expected all zero",
                     i, y, valid, busy, done);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      scan_check("post_reset_scan", 1, 0, 1'b0, -1, 0);
   endtask

   task automatic test_random_scans();
      for (int i = 0; i < 4; i++)
         scan_check("random_scan", int'($urandom_range(0, 5)), 25, 1'b1, -1, 0);
   endtask

`ifdef DECODER_SCAN_WRAP_EN
   task automatic test_wrap();
      logic [OUT_W-1:0] ey;
      logic [2:0]       evbd;
      en    = 1'b1;
      mode  = 1'b1;
      dwell = DWELL_W'(1);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k <= 3 * OUT_W; k++) begin
         if (k < 3 * OUT_W) begin
            ey   = OUT_W'(1) << (k % OUT_W);
            evbd = {2'b11, (k > 0 && (k % OUT_W) == 0)};
         end else begin
            ey   = '0;
            evbd = 3'b001;
         end
         n_checks++;
         if ({y, valid, busy, done} !== {ey, evbd}) begin
            n_fail++;
            $display("FAIL wrap k=%0d: y=%h v=%b b=%b d=%b, expected y=%h vbd=%b",
                     k, y, valid, busy, done, ey, evbd);
         end
         if (k == 2 * OUT_W + 4) mode = 1'b0;
         if (k < 3 * OUT_W) step();
      end
      step();
      n_checks++;
      if ({y, valid, busy, done} !== {OUT_W'(0), 3'b000}) begin
         n_fail++;
         $display("FAIL wrap_end: y=%h v=%b b=%b d=%b, expected all zero", y, valid, busy, done);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_direct();
      test_simultaneous();
      scan_check("scan_dwell2", 2, 0, 1'b0, -1, 0);
      scan_check("scan_dwell0", 0, 0, 1'b0, -1, 0);
      scan_check("scan_freeze", 2, 0, 1'b1, 4, 3);
      test_reset_mid_scan();
      test_random_scans();
`ifdef DECODER_SCAN_WRAP_EN
      test_wrap();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
